// File: rtl/if_stage.sv
`default_nettype none
// ============================================================================
// Module      : if_stage
// Description : MIPS instruction-fetch stage. It holds the PC, selects the next
//               PC, and loads the IF/ID register. It also keeps a saturating
//               count of taken branches.
// Revision    : 1.0 - initial release
// ============================================================================
module if_stage #(
    parameter int unsigned            WIDTH     = 32,
    parameter logic [WIDTH-1:0]       RESET_PC  = '0,
    parameter int unsigned            PC_STEP   = 4,
    parameter int unsigned            CNT_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pc_src,
    input  logic [WIDTH-1:0]      branch_target,
    input  logic                  stall,
    output logic [WIDTH-1:0]      imem_addr,
    input  logic [WIDTH-1:0]      imem_instr,
    output logic [WIDTH-1:0]      pc,
    output logic [WIDTH-1:0]      if_id_pc4,
    output logic [WIDTH-1:0]      if_id_instr,
    output logic                  if_id_valid,
    output logic [CNT_WIDTH-1:0]  taken_count
);

    typedef enum logic [0:0] {
        BOOT = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t                 r_state;
    logic [WIDTH-1:0]       r_pc;
    logic [WIDTH-1:0]       r_pc4;
    logic [WIDTH-1:0]       r_instr;
    logic                   r_valid;
    logic [CNT_WIDTH-1:0]   r_cnt;

    logic [WIDTH-1:0]       w_pc_plus;
    logic [WIDTH-1:0]       w_target;

    // The sequential increment wraps modulo 2^WIDTH. Branch targets are always word aligned.
    assign w_pc_plus = r_pc + WIDTH'(PC_STEP);
    assign w_target  = branch_target & ~WIDTH'(3);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= BOOT;
            r_pc    <= RESET_PC;
            r_pc4   <= '0;
            r_instr <= '0;
            r_valid <= 1'b0;
            r_cnt   <= '0;
        end else if (pc_src) begin
            r_state <= RUN;
            r_pc    <= w_target;
            r_pc4   <= '0;
            r_instr <= '0;
            r_valid <= 1'b0;
            if (~&r_cnt)
                r_cnt <= r_cnt + 1'b1;
        end else if (stall || r_state == BOOT) begin
            // The BOOT cycle behaves like a stall, because IF/ID is already cleared.
            r_state <= RUN;
        end else begin
            r_pc    <= w_pc_plus;
            r_pc4   <= w_pc_plus;
            r_instr <= imem_instr;
            r_valid <= 1'b1;
        end
    end

    assign imem_addr   = r_pc;
    assign pc          = r_pc;
    assign if_id_pc4   = r_pc4;
    assign if_id_instr = r_instr;
    assign if_id_valid = r_valid;
    assign taken_count = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_if_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_if_stage
// Description : Directed self-checking bench for if_stage. It uses a default
//               instance and a wrap/saturate instance.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_if_stage;

    logic        clk = 1'b0;
    logic        rst, pc_src, stall;
    logic [31:0] branch_target;
    logic [31:0] imem_addr, imem_instr, pc, if_id_pc4, if_id_instr;
    logic        if_id_valid;
    logic [15:0] taken_count;

    logic        rst2, pc_src2;
    logic [31:0] branch_target2;
    logic [31:0] imem_addr2, imem_instr2, pc2, if_id_pc42, if_id_instr2;
    logic        if_id_valid2;
    logic [3:0]  taken_count2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign imem_instr  = imem_addr  ^ 32'hA5A5_0000;
    assign imem_instr2 = imem_addr2 ^ 32'hA5A5_0000;

    if_stage dut (
        .clk           (clk),
        .rst           (rst),
        .pc_src        (pc_src),
        .branch_target (branch_target),
        .stall         (stall),
        .imem_addr     (imem_addr),
        .imem_instr    (imem_instr),
        .pc            (pc),
        .if_id_pc4     (if_id_pc4),
        .if_id_instr   (if_id_instr),
        .if_id_valid   (if_id_valid),
        .taken_count   (taken_count)
    );

    if_stage #(
        .WIDTH     (32),
        .RESET_PC  (32'hFFFF_FFF8),
        .PC_STEP   (4),
        .CNT_WIDTH (4)
    ) dut2 (
        .clk           (clk),
        .rst           (rst2),
        .pc_src        (pc_src2),
        .branch_target (branch_target2),
        .stall         (1'b0),
        .imem_addr     (imem_addr2),
        .imem_instr    (imem_instr2),
        .pc            (pc2),
        .if_id_pc4     (if_id_pc42),
        .if_id_instr   (if_id_instr2),
        .if_id_valid   (if_id_valid2),
        .taken_count   (taken_count2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_ifid(input string tag, input logic [31:0] e_pc,
                              input logic [31:0] e_instr, input logic [31:0] e_pc4,
                              input logic e_valid);
        check({tag, ".pc"},    pc,          e_pc);
        check({tag, ".addr"},  imem_addr,   e_pc);
        check({tag, ".instr"}, if_id_instr, e_instr);
        check({tag, ".pc4"},   if_id_pc4,   e_pc4);
        check({tag, ".valid"}, {31'd0, if_id_valid}, {31'd0, e_valid});
    endtask

    initial begin
        rst = 1'b1; pc_src = 1'b0; stall = 1'b0; branch_target = '0;
        rst2 = 1'b1; pc_src2 = 1'b0; branch_target2 = '0;

        // Reset is held for two edges.
        step(); step();
        check_ifid("reset", 32'h0, 32'h0, 32'h0, 1'b0);
        check("reset.cnt", {16'd0, taken_count}, 32'd0);

        // The first edge after reset is the BOOT cycle.
        rst = 1'b0;
        step();
        check_ifid("boot", 32'h0, 32'h0, 32'h0, 1'b0);

        // Sequential fetch
        step(); check_ifid("seq1", 32'h4, 32'hA5A5_0000, 32'h4, 1'b1);
        step(); check_ifid("seq2", 32'h8, 32'hA5A5_0004, 32'h8, 1'b1);

        // Stall at pc=8 for three cycles
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(); check_ifid("stall", 32'h8, 32'hA5A5_0004, 32'h8, 1'b1);
        end
        stall = 1'b0;
        step(); check_ifid("resume", 32'hC, 32'hA5A5_0008, 32'hC, 1'b1);

        // Taken branch to an unaligned target
        pc_src = 1'b1; branch_target = 32'h0000_0103;
        step(); check_ifid("br", 32'h100, 32'h0, 32'h0, 1'b0);
        check("br.cnt", {16'd0, taken_count}, 32'd1);
        pc_src = 1'b0; branch_target = '0;
        step(); check_ifid("br.fetch", 32'h104, 32'hA5A5_0100, 32'h104, 1'b1);

        // A branch and a stall in the same cycle: the branch wins.
        pc_src = 1'b1; stall = 1'b1; branch_target = 32'h40;
        step(); check_ifid("brstall", 32'h40, 32'h0, 32'h0, 1'b0);
        check("brstall.cnt", {16'd0, taken_count}, 32'd2);
        pc_src = 1'b0; stall = 1'b0;

        // Reset asserted during a stall
        stall = 1'b1; rst = 1'b1;
        step(); check_ifid("rststall", 32'h0, 32'h0, 32'h0, 1'b0);
        check("rststall.cnt", {16'd0, taken_count}, 32'd0);

        // A branch during BOOT is honoured and the stage moves to RUN.
        rst = 1'b0; stall = 1'b0; pc_src = 1'b1; branch_target = 32'h20;
        step(); check_ifid("bootbr", 32'h20, 32'h0, 32'h0, 1'b0);
        check("bootbr.cnt", {16'd0, taken_count}, 32'd1);
        pc_src = 1'b0;
        step(); check_ifid("bootbr.run", 32'h24, 32'hA5A5_0020, 32'h24, 1'b1);

        // PC wrap on the second instance
        rst2 = 1'b0;
        step(); check("wrap.boot", pc2, 32'hFFFF_FFF8);
        step(); check("wrap.pc1", pc2, 32'hFFFF_FFFC);
        check("wrap.pc4_1", if_id_pc42, 32'hFFFF_FFFC);
        step(); check("wrap.pc2", pc2, 32'h0);
        check("wrap.pc4_2", if_id_pc42, 32'h0);
        check("wrap.instr", if_id_instr2, 32'h5A5A_FFFC);
        check("wrap.valid", {31'd0, if_id_valid2}, 32'd1);

        // Counter saturation with 17 pulses
        pc_src2 = 1'b1; branch_target2 = 32'h80;
        step(); check("sat.c1", {28'd0, taken_count2}, 32'd1);
        for (int i = 1; i < 15; i++) step();
        check("sat.c15", {28'd0, taken_count2}, 32'hF);
        step(); step();
        check("sat.c17", {28'd0, taken_count2}, 32'hF);
        check("sat.pc", pc2, 32'h80);
        pc_src2 = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
